pulse_train_generator: RTL

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

---
 rtl/pulse_train_generator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pulse_train_generator.sv
// Multi-channel pulse train generator: each channel runs an independent period/width
// counter in continuous, one-shot or burst mode, with start/stop strobes and a done pulse.
module pulse_train_generator #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4,
  parameter int unsigned B  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [CH*N-1:0]   period,
  input  logic [CH*N-1:0]   width,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH*B-1:0]   burst_len,
  input  logic [CH-1:0]     start,
  input  logic [CH-1:0]     stop,
  output logic [CH-1:0]     out,
  output logic [CH-1:0]     busy,
  output logic [CH-1:0]     done
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [1:0] ModeOff   = 2'b00;
  localparam logic [1:0] ModeCont  = 2'b01;
  localparam logic [1:0] ModeOne   = 2'b10;
  localparam logic [1:0] ModeBurst = 2'b11;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [B-1:0]   cyc_q, cyc_d;
    logic [N-1:0]   period_q, period_d;
    logic [N-1:0]   width_q, width_d;
    logic [1:0]     mode_q, mode_d;
    logic [B-1:0]   blen_q, blen_d;
    logic           out_q, out_d;
    logic           done_q, done_d;

    logic [N-1:0]   period_in, width_in;
    logic [1:0]     mode_in;
    logic [B-1:0]   blen_in;
    logic [B-1:0]   blen_last;
    logic           cycle_end;
    logic           finish;

    assign period_in = period[i*N +: N];
    assign width_in  = width[i*N +: N];
    assign mode_in   = mode[2*i +: 2];
    assign blen_in   = burst_len[i*B +: B];

    // A burst length of zero runs a single cycle, same as a length of one.
    assign blen_last = (blen_q == '0) ? '0 : blen_q - B'(1);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      period_d  = period_q;
      width_d   = width_q;
      mode_d    = mode_q;
      blen_d    = blen_q;
      out_d     = out_q;
      done_d    = 1'b0;
      cycle_end = 1'b0;
      finish    = 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start[i] && !stop[i] && (mode_in != ModeOff)) begin
            state_d  = StRun;
            period_d = period_in;
            width_d  = width_in;
            mode_d   = mode_in;
            blen_d   = blen_in;
            cnt_d    = '0;
            cyc_d    = '0;
            out_d    = (width_in != '0);
          end
        end
        StRun: begin
          if (ena) begin
            cycle_end = (cnt_q == period_q);
            if (!cycle_end) begin
              cnt_d = cnt_q + N'(1);
              out_d = (cnt_d < width_q);
            end else begin
              cnt_d = '0;
              unique case (mode_q)
                ModeCont: begin
                  // Continuous mode picks up new settings at every cycle boundary.
                  period_d = period_in;
                  width_d  = width_in;
                  mode_d   = mode_in;
                  blen_d   = blen_in;
                  cyc_d    = '0;
                  if (mode_in == ModeOff) begin
                    finish = 1'b1;
                  end else begin
                    out_d = (width_in != '0);
                  end
                end
                ModeBurst: begin
                  if (cyc_q == blen_last) begin
                    finish = 1'b1;
                  end else begin
                    cyc_d = cyc_q + B'(1);
                    out_d = (width_q != '0);
                  end
                end
                ModeOne: finish = 1'b1;
                ModeOff: finish = 1'b1;
              endcase
            end
          end
        end
      endcase

      if (finish) begin
        state_d = StIdle;
        out_d   = 1'b0;
        cyc_d   = '0;
        done_d  = 1'b1;
      end

      // Abort overrides start and cycle end, and never reports completion.
      if (stop[i]) begin
        state_d = StIdle;
        out_d   = 1'b0;
        cnt_d   = '0;
        cyc_d   = '0;
        done_d  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        cyc_q    <= '0;
        period_q <= '0;
        width_q  <= '0;
        mode_q   <= ModeOff;
        blen_q   <= '0;
        out_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        cyc_q    <= cyc_d;
        period_q <= period_d;
        width_q  <= width_d;
        mode_q   <= mode_d;
        blen_q   <= blen_d;
        out_q    <= out_d;
        done_q   <= done_d;
      end
    end

    assign out[i]  = out_q;
    assign busy[i] = (state_q == StRun);
    assign done[i] = done_q;
  end

endmodule
